// File: rtl/speaker_pkg.sv
// Shared definitions for the speaker/tone datapath: table entry layout,
// sequencer state encoding and a pitch helper for composing tables.
package speaker_pkg;

    localparam int ENTRY_W = 24;
    localparam int HP_W    = 20;
    localparam int DUR_W   = 4;
    localparam int DUR_LSB = 20;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP
    } seq_state_t;

    // Half-period in clocks for a tone of f Hz: clk_hz / (2 * f).
    function automatic int unsigned hz_to_half_period(input int unsigned clk_hz,
                                                      input int unsigned f);
        return clk_hz / (2 * f);
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Reloadable half-period counter driving a square-wave toggle flop.
// load restarts the waveform low; with en low the output is parked at 0.
// A half_period of 0 is a rest: the output never toggles.
module tone_gen
    import speaker_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            en,
    input  logic            load,
    input  logic [HP_W-1:0] half_period,
    output logic            speaker
);

    logic [HP_W-1:0] cnt_q, cnt_d;
    logic            spk_q, spk_d;

    // Next counter/toggle value: reload on load, park low when disabled.
    always_comb begin
        cnt_d = cnt_q;
        spk_d = spk_q;
        if (load) begin
            cnt_d = half_period - HP_W'(1);
            spk_d = 1'b0;
        end else if (!en) begin
            spk_d = 1'b0;
        end else if (half_period != '0) begin
            if (cnt_q == '0) begin
                spk_d = ~spk_q;
                cnt_d = half_period - HP_W'(1);
            end else begin
                cnt_d = cnt_q - HP_W'(1);
            end
        end
    end

    // Counter and output flop with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
            spk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            spk_q <= spk_d;
        end
    end

    assign speaker = spk_q;

endmodule

// File: rtl/melody_sequencer.sv
// Plays a programmable table of {duration, half-period} notes on the speaker
// pin, inserting a fixed silent gap after each note. The table is writable
// only while idle; playback is started/aborted by the composer logic.
module melody_sequencer
    import speaker_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int SEQ_LEN     = 16,
    parameter int TICK_CYCLES = CLK_HZ / 16,
    parameter int GAP_CYCLES  = CLK_HZ / 200
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop_en,
    input  logic                       wr_en,
    input  logic [$clog2(SEQ_LEN)-1:0] wr_addr,
    input  logic [ENTRY_W-1:0]         wr_data,
    output logic                       speaker,
    output logic                       sound,
    output logic                       busy,
    output logic [$clog2(SEQ_LEN)-1:0] note_idx,
    output logic                       done
);

    localparam int IDX_W  = $clog2(SEQ_LEN);
    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SEQ_LEN - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    seq_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [DUR_W-1:0]  durc_q, durc_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    logic [ENTRY_W-1:0] tbl_q [SEQ_LEN];
    logic [ENTRY_W-1:0] rd_q;
    logic [DUR_W-1:0]   rd_dur;
    logic [HP_W-1:0]    rd_hp;

    logic seq_end;
    logic done_w;
    logic tone_load;
    logic tone_en;

    assign rd_dur = rd_q[DUR_LSB +: DUR_W];
    assign rd_hp  = rd_q[HP_W-1:0];

    // Note table: writes only while idle; the read port follows the next index
    // so the entry is already registered when LOAD is entered.
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == IDLE)) begin
            tbl_q[wr_addr] <= wr_data;
        end
        rd_q <= tbl_q[idx_d];
    end

    // Next-state logic: note timing, gap timing, end-of-sequence and abort.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tick_d    = tick_q;
        durc_d    = durc_q;
        gap_d     = gap_q;
        seq_end   = 1'b0;
        done_w    = 1'b0;
        tone_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                if (rd_dur != '0) begin
                    state_d   = PLAY;
                    tick_d    = '0;
                    durc_d    = '0;
                    tone_load = 1'b1;
                end else begin
                    seq_end = 1'b1;
                end
            end
            PLAY: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (durc_q == rd_dur - DUR_W'(1)) begin
                        state_d = GAP;
                        gap_d   = '0;
                    end else begin
                        durc_d = durc_q + DUR_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
                    if (idx_q == IDX_LAST) begin
                        seq_end = 1'b1;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = LOAD;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Either wrap for looping playback or finish with a done pulse.
        if (seq_end) begin
            if (loop_en) begin
                idx_d   = '0;
                state_d = LOAD;
            end else begin
                state_d = IDLE;
                done_w  = 1'b1;
            end
        end

        // Abort overrides everything, including a simultaneous start.
        if (stop) begin
            state_d   = IDLE;
            idx_d     = idx_q;
            done_w    = 1'b0;
            tone_load = 1'b0;
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tick_q  <= '0;
            durc_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            durc_q  <= durc_d;
            gap_q   <= gap_d;
        end
    end

    // The tone keeps running only while PLAY continues, so the speaker drops
    // to 0 on the edge that leaves PLAY for any reason.
    assign tone_en = (state_q == PLAY) && (state_d == PLAY);

    tone_gen u_tone_gen (
        .clk         (clk),
        .resetn      (resetn),
        .en          (tone_en),
        .load        (tone_load),
        .half_period (rd_hp),
        .speaker     (speaker)
    );

    assign sound    = (state_q == PLAY) && (rd_hp != '0);
    assign busy     = (state_q != IDLE);
    assign note_idx = idx_q;
    assign done     = done_w;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer with a small table and short tick/gap so whole
// melodies fit in a few hundred cycles. Expected per-cycle outputs come from
// a note-level model that expands the table into a cycle trace.
module tb_melody_sequencer;

    localparam int SEQ_LEN = 4;
    localparam int TICK    = 10;
    localparam int GAP     = 4;
    localparam int MAXT    = 1024;

    logic        clk     = 1'b0;
    logic        resetn  = 1'b0;
    logic        start   = 1'b0;
    logic        stop    = 1'b0;
    logic        loop_en = 1'b0;
    logic        wr_en   = 1'b0;
    logic [1:0]  wr_addr = 2'd0;
    logic [23:0] wr_data = 24'd0;
    logic        speaker;
    logic        sound;
    logic        busy;
    logic [1:0]  note_idx;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;

    int         tb_dur [SEQ_LEN];
    int         tb_hp  [SEQ_LEN];
    logic [5:0] exp_vec [MAXT];   // {busy, speaker, sound, done, note_idx}
    int         mt;
    int         drop_at;

    melody_sequencer #(
        .CLK_HZ      (160),
        .SEQ_LEN     (SEQ_LEN),
        .TICK_CYCLES (TICK),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .speaker  (speaker),
        .sound    (sound),
        .busy     (busy),
        .note_idx (note_idx),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic push(input bit b, input bit sp, input bit so, input bit dn, input int ix);
        if (mt < MAXT) exp_vec[mt] = {b, sp, so, dn, 2'(ix)};
        mt++;
    endtask

    // Expand the table into the expected cycle trace, cycle 0 being the one
    // right after the start edge. loops = number of wraps before the final
    // pass; drop_at = first cycle where loop_en is driven low.
    task automatic build_trace(input int loops, input int tail);
        int idx, wraps, dur, hp;
        bit fin, wrap, last;
        mt = 0; idx = 0; wraps = 0; fin = 1'b0;
        drop_at = (loops > 0) ? MAXT : 0;
        while (!fin && mt < MAXT - 200) begin
            dur  = tb_dur[idx];
            hp   = tb_hp[idx];
            if (loops > 0 && wraps == loops && idx == SEQ_LEN - 1) drop_at = mt;
            wrap = (wraps < loops);
            last = (idx == SEQ_LEN - 1);
            if (dur == 0) begin
                push(1, 0, 0, !wrap, idx);
            end else begin
                push(1, 0, 0, 0, idx);
                for (int j = 0; j < dur * TICK; j++)
                    push(1, (hp != 0) ? ((j / hp) % 2 == 1) : 1'b0, hp != 0, 0, idx);
                for (int g = 0; g < GAP; g++)
                    push(1, 0, 0, (g == GAP - 1) && last && !wrap, idx);
            end
            if (dur != 0 && !last) begin
                idx++;
            end else if (wrap) begin
                wraps++;
                idx = 0;
                if (wraps == loops && drop_at == MAXT) drop_at = mt;
            end else begin
                fin = 1'b1;
            end
        end
        for (int k = 0; k < tail; k++) push(0, 0, 0, 0, idx);
    endtask

    // Pulse start, then compare every cycle of the trace. With noise set,
    // start is toggled randomly while the sequencer is expected to be busy.
    task automatic run_trace(input string name, input bit noise);
        logic [5:0] obs;
        int total;
        total = (mt < MAXT) ? mt : MAXT;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < total; t++) begin
            loop_en = (t < drop_at);
            start   = noise && exp_vec[t][5] && ($urandom_range(0, 3) == 0);
            #1;
            obs = {busy, speaker, sound, done, note_idx};
            vectors++;
            if (obs !== exp_vec[t]) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got %b expected %b (busy,spk,snd,done,idx)",
                         name, t, obs, exp_vec[t]);
            end
            @(posedge clk); #1;
        end
        start   = 1'b0;
        loop_en = 1'b0;
    endtask

    task automatic write_entry(input int addr, input int dur, input int hp);
        wr_addr = 2'(addr);
        wr_data = {4'(dur), 20'(hp)};
        wr_en   = 1'b1;
        @(posedge clk); #1;
        wr_en   = 1'b0;
        tb_dur[addr] = dur;
        tb_hp[addr]  = hp;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        start  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0)     begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (speaker !== 1'b0)  begin miscompares++; $display("FAIL reset_speaker: got %b expected 0", speaker); end
        vectors++; if (sound !== 1'b0)    begin miscompares++; $display("FAIL reset_sound: got %b expected 0", sound); end
        vectors++; if (done !== 1'b0)     begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
        vectors++; if (note_idx !== 2'd0) begin miscompares++; $display("FAIL reset_idx: got %0d expected 0", note_idx); end
        start = 1'b1;
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_start_held: got busy %b expected 0", busy); end
        start  = 1'b0;
        resetn = 1'b1;
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_release: got busy %b expected 0", busy); end
    endtask

    task automatic test_single_note;
        write_entry(0, 2, 5);
        write_entry(1, 0, 0);
        build_trace(0, 4);
        run_trace("single_note", 1'b0);
    endtask

    task automatic test_rest;
        write_entry(0, 1, 0);
        write_entry(1, 0, 0);
        build_trace(0, 4);
        run_trace("rest", 1'b0);
    endtask

    task automatic test_loop;
        for (int i = 0; i < SEQ_LEN; i++) write_entry(i, 1, 3);
        build_trace(2, 4);
        run_trace("loop", 1'b0);
    endtask

    task automatic test_random;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < SEQ_LEN; i++)
                write_entry(i, $urandom_range(0, 3), $urandom_range(0, 6));
            build_trace($urandom_range(0, 1), 3);
            run_trace("random", 1'b1);
        end
    endtask

    task automatic test_abort_and_protect;
        logic [5:0] obs;
        bit         seen_done;
        write_entry(0, 3, 4);
        write_entry(1, 1, 2);
        write_entry(2, 0, 0);
        build_trace(0, 4);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t <= 6; t++) begin
            #1;
            obs = {busy, speaker, sound, done, note_idx};
            vectors++;
            if (obs !== exp_vec[t]) begin
                miscompares++;
                $display("FAIL abort_pre cycle %0d: got %b expected %b", t, obs, exp_vec[t]);
            end
            wr_en   = (t == 3) || (t == 4);
            wr_addr = (t == 3) ? 2'd0 : 2'd1;
            wr_data = {4'd5, 20'd9};
            stop    = (t == 6);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        stop  = 1'b0;
        vectors++; if (busy !== 1'b0)    begin miscompares++; $display("FAIL abort_busy: got %b expected 0", busy); end
        vectors++; if (speaker !== 1'b0) begin miscompares++; $display("FAIL abort_speaker: got %b expected 0", speaker); end
        vectors++; if (sound !== 1'b0)   begin miscompares++; $display("FAIL abort_sound: got %b expected 0", sound); end
        seen_done = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
            @(posedge clk); #1;
        end
        vectors++; if (seen_done) begin miscompares++; $display("FAIL abort_quiet: got activity after stop, expected none"); end
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL start_stop_idle: got busy %b expected 0", busy); end
        run_trace("write_protect_replay", 1'b0);
    endtask

    task automatic test_reset_mid;
        logic [5:0] obs;
        write_entry(0, 1, 3);
        write_entry(1, 1, 5);
        write_entry(2, 0, 0);
        build_trace(0, 4);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t <= 27; t++) begin
            #1;
            obs = {busy, speaker, sound, done, note_idx};
            vectors++;
            if (obs !== exp_vec[t]) begin
                miscompares++;
                $display("FAIL reset_mid_pre cycle %0d: got %b expected %b", t, obs, exp_vec[t]);
            end
            resetn = (t != 27);
            @(posedge clk); #1;
        end
        resetn = 1'b1;
        obs = {busy, speaker, sound, done, note_idx};
        vectors++;
        if (obs !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got %b expected 000000", obs);
        end
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_mid_idle: got busy %b expected 0", busy); end
        run_trace("reset_mid_replay", 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_rest();
        test_loop();
        test_random();
        test_abort_and_protect();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Sequences the square-wave speaker datapath through a programmable table of notes. Each entry gives a pitch and a duration.
- Contains the note table, a duration timer and a variable-pitch tone generator. Drives the speaker pin directly.
- Sits between the user-input/composer logic (which programs the table and issues start/stop) and the board speaker output.

Parameters:
- CLK_HZ, 50000000, system clock frequency; documentation and default derivation only.
- SEQ_LEN, 16, number of table entries (power of 2, ≥2).
- TICK_CYCLES, 3125000, clocks per duration tick (1/16 s at 50 MHz).
- GAP_CYCLES, 250000, silent clocks inserted after every note (articulation).

Ports:
- clk  in  1  system clock; single clock domain.
- resetn  in  1  reset. One clock; reset is synchronous and active-low.
- start  in  1  begin playback from entry 0; honoured only in IDLE.
- stop  in  1  abort playback; honoured in any state; wins over start.
- loop_en  in  1  when 1, wrap to entry 0 instead of finishing; sampled at end of sequence.
- wr_en  in  1  table write strobe; honoured only in IDLE.
- wr_addr  in  $clog2(SEQ_LEN)  table write address.
- wr_data  in  24  entry: [23:20] dur (ticks), [19:0] half_period (clocks).
- speaker  out  1  square-wave output.
- sound  out  1  high while a non-rest note is sounding.
- busy  out  1  high in any state except IDLE.
- note_idx  out  $clog2(SEQ_LEN)  index of the current entry.
- done  out  1  one-cycle pulse on natural sequence completion.

Behaviour:
- Reset (resetn=0 at an edge): state=IDLE; speaker=0, sound=0, busy=0, done=0, note_idx=0; all counters 0. Table contents are NOT cleared.
- Entry semantics:
  - dur=0 is the end-of-sequence marker.
  - half_period=0 is a rest: timed like a note, speaker held 0, sound=0.
- States: IDLE, LOAD, PLAY, GAP.
- IDLE:
  - wr_en writes table[wr_addr] at the edge.
  - start (with stop=0) → LOAD, note_idx=0.
  - Writes in any other state are ignored.
- LOAD (1 cycle): registered table read of note_idx.
  - dur≠0 → PLAY, with the tick and duration counters cleared, speaker=0 and the half-period counter loaded with half_period-1.
  - dur=0 → end handling.
- PLAY:
  - Lasts exactly dur×TICK_CYCLES clocks.
  - Non-rest note: speaker toggles when the half-period counter reaches 0; the counter then reloads half_period-1. The first toggle occurs half_period cycles after PLAY entry. sound=1 throughout.
  - On the last PLAY cycle → GAP.
- GAP:
  - Lasts GAP_CYCLES clocks; speaker=0, sound=0.
  - Then: if note_idx==SEQ_LEN-1 → end handling; else note_idx+1 → LOAD.
- End handling:
  - loop_en=1 → note_idx=0, LOAD; no done pulse.
  - loop_en=0 → IDLE, done=1 for one cycle, note_idx unchanged.
- stop in any non-IDLE state: next edge → IDLE; speaker=0, sound=0, no done.
- start while busy: ignored. start and stop together: stop wins.
- speaker is forced to 0 outside PLAY, so it never idles high (unlike a free-running toggler).
- Counter widths: tick counter $clog2(TICK_CYCLES), dur counter 4 bits, half-period counter 20 bits. No overflow is possible by construction.

Decomposition:
- Package speaker_pkg:
  - Constants: ENTRY_W=24, HP_W=20, DUR_W=4, DUR_LSB=20.
  - State enum: seq_state_t {IDLE, LOAD, PLAY, GAP}.
  - Helper function hz_to_half_period(clk_hz, f) = clk_hz/(2f).
- Sub-module tone_gen (clk, resetn, en, load, half_period[19:0] → speaker): the reloadable half-period counter/toggle flop. Reused by other tone sources.
- The table is an inferred SEQ_LEN×24 register array with a registered read.

Test Plan:
Bench parameters: SEQ_LEN=4, TICK_CYCLES=10, GAP_CYCLES=4.
- Reset with resetn=0 for 2 cycles → speaker=0, sound=0, busy=0, done=0, note_idx=0. Then hold start=1 in reset → still IDLE.
- Single note:
  - Stimulus: write e0={dur=2,hp=5}, e1={dur=0}; pulse start at edge k.
  - LOAD at k. PLAY for cycles k+1..k+20, with speaker toggling at k+5, k+10, k+15, k+20 (4 toggles). GAP for k+21..k+24.
  - done=1 only at k+25; busy then 0.
- Rest:
  - Stimulus: e0={dur=1,hp=0}, e1={dur=0}; start.
  - speaker=0 and sound=0 for the full 10 PLAY cycles; done after 1+10+4 cycles.
- Loop:
  - Stimulus: all 4 entries with dur=1, hp=3; loop_en=1.
  - note_idx goes 0,1,2,3,0… with no done.
  - Drop loop_en during entry 3 → done after entry 3's GAP.
- Abort and write protection:
  - stop mid-PLAY → next cycle busy=0, speaker=0, sound=0, done never asserted.
  - wr_en during PLAY → entry unchanged on replay.
  - start+stop together in IDLE → remains IDLE.
- Reset mid-operation: resetn=0 during GAP → all outputs reset at the next edge; table contents retained, so a new start replays the same melody.
